// File: rtl/cpu_pkg.sv
// Shared types for the parametrised accumulator core: opcodes, FSM states
// and command field extraction helpers.
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'h0,
    OP_SUB   = 4'h1,
    OP_MUL   = 4'h2,
    OP_AND   = 4'h3,
    OP_OR    = 4'h4,
    OP_XOR   = 4'h5,
    OP_NOT   = 4'h6,
    OP_SHL   = 4'h7,
    OP_SHR   = 4'h8,
    OP_PASS  = 4'h9,
    OP_LOAD  = 4'hC,
    OP_STORE = 4'hD,
    OP_NOP   = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    MEMRD,
    DONE
  } state_e;

  // cmd layout: {opcode[3:0], sel_a[sel_w], sel_b[sel_w]}
  function automatic logic [3:0] cmd_op(
    input logic [31:0] cmd,
    input int unsigned sel_w
  );
    return cmd[2*sel_w +: 4];
  endfunction

  function automatic logic [15:0] cmd_sel_a(
    input logic [31:0] cmd,
    input int unsigned sel_w
  );
    logic [31:0] m;
    m = (32'd1 << sel_w) - 32'd1;
    return 16'((cmd >> sel_w) & m);
  endfunction

  function automatic logic [15:0] cmd_sel_b(
    input logic [31:0] cmd,
    input int unsigned sel_w
  );
    logic [31:0] m;
    m = (32'd1 << sel_w) - 32'd1;
    return 16'(cmd & m);
  endfunction

endpackage

// File: rtl/cpu_core_param_if.sv
// Command/data/result bundle of cpu_core_param.
// master: command source side; slave: the core.
interface cpu_core_param_if #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4
);
  localparam int SEL_W = $clog2(NUM_IN);
  localparam int CMD_W = 4 + 2*SEL_W;

  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [CMD_W-1:0]        cmd_in;
  logic [NUM_IN*WIDTH-1:0] din;
  logic [2*WIDTH-1:0]      result;
  logic                    cpu_rdy;
  logic                    zero;
  logic                    error;

  modport master (
    output cmd_valid, cmd_in, din,
    input  cmd_ready, result, cpu_rdy, zero, error
  );

  modport slave (
    input  cmd_valid, cmd_in, din,
    output cmd_ready, result, cpu_rdy, zero, error
  );
endinterface

// File: rtl/cpu_alu_param.sv
// Combinational ALU: zero-extended WIDTH operands, 2*WIDTH result.
// Ports: op, a, b in; res, valid_op (op is an ALU opcode) out.
module cpu_alu_param
  import cpu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] res,
  output logic               valid_op
);
  logic [2*WIDTH-1:0] ax;
  logic [2*WIDTH-1:0] bx;

  assign ax = {{WIDTH{1'b0}}, a};
  assign bx = {{WIDTH{1'b0}}, b};

  always_comb begin
    res      = '0;
    valid_op = 1'b1;
    unique case (op)
      OP_ADD:  res = ax + bx;
      OP_SUB:  res = ax - bx;
      OP_MUL:  res = ax * bx;
      OP_AND:  res = ax & bx;
      OP_OR:   res = ax | bx;
      OP_XOR:  res = ax ^ bx;
      OP_NOT:  res = {{WIDTH{1'b0}}, ~a};
      OP_SHL:  res = ax << 1;
      OP_SHR:  res = ax >> 1;
      OP_PASS: res = ax;
      default: valid_op = 1'b0;
    endcase
  end
endmodule

// File: rtl/cpu_core_param.sv
// Parametrised accumulator core: valid/ready command, operand fetch,
// ALU, sync RAM load/store. Ports: clk, reset (async low), bus (slave).
module cpu_core_param
  import cpu_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NUM_IN    = 4,
  parameter int MEM_DEPTH = 256
) (
  input logic           clk,
  input logic           reset,
  cpu_core_param_if.slave bus
);
  localparam int SEL_W  = $clog2(NUM_IN);
  localparam int ADDR_W = $clog2(MEM_DEPTH);
  localparam int CMD_W  = 4 + 2*SEL_W;
  localparam int RW     = 2*WIDTH;

  state_e             state;
  logic [CMD_W-1:0]   cmd_q;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic               sel_err;
  logic [RW-1:0]      result_q;
  logic               zero_q;
  logic               error_q;
  logic               rdy_q;

  logic [3:0]         op;
  logic [SEL_W-1:0]   sel_a;
  logic [SEL_W-1:0]   sel_b;
  logic               bad_a;
  logic               bad_b;
  logic [WIDTH-1:0]   mux_a;
  logic [WIDTH-1:0]   mux_b;
  logic [RW-1:0]      alu_res;
  logic               alu_ok;
  logic               is_load;
  logic               known;

  logic [RW-1:0]      mem [MEM_DEPTH];
  logic [RW-1:0]      rd_data;
  logic [ADDR_W-1:0]  addr;
  logic               mem_we;

  assign op    = cmd_op(32'(cmd_q), SEL_W);
  assign sel_a = SEL_W'(cmd_sel_a(32'(cmd_q), SEL_W));
  assign sel_b = SEL_W'(cmd_sel_b(32'(cmd_q), SEL_W));

  // out-of-range channel reads as zero and flags the command
  assign bad_a = int'(sel_a) >= NUM_IN;
  assign bad_b = int'(sel_b) >= NUM_IN;
  assign mux_a = bad_a ? '0
               : bus.din[int'(sel_a)*WIDTH +: WIDTH];
  assign mux_b = bad_b ? '0
               : bus.din[int'(sel_b)*WIDTH +: WIDTH];

  cpu_alu_param #(
    .WIDTH(WIDTH)
  ) u_alu (
    .op      (op),
    .a       (op_a),
    .b       (op_b),
    .res     (alu_res),
    .valid_op(alu_ok)
  );

  assign is_load = op == OP_LOAD;
  assign known   = alu_ok | is_load
                 | (op == OP_STORE)
                 | (op == OP_NOP);

  // write gated by EXEC state, so an async reset
  // before the EXEC edge suppresses the store
  assign addr   = op_a[ADDR_W-1:0];
  assign mem_we = (state == EXEC) && (op == OP_STORE);

  always_ff @(posedge clk) begin
    if (mem_we)
      mem[addr] <= result_q;
    rd_data <= mem[addr];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cmd_q    <= '0;
      op_a     <= '0;
      op_b     <= '0;
      sel_err  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      error_q  <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            cmd_q <= bus.cmd_in;
            state <= FETCH;
          end
        end
        FETCH: begin
          op_a    <= mux_a;
          op_b    <= mux_b;
          sel_err <= bad_a | bad_b;
          state   <= EXEC;
        end
        EXEC: begin
          error_q <= sel_err | ~known;
          if (alu_ok) begin
            result_q <= alu_res;
            zero_q   <= alu_res == '0;
          end
          state <= is_load ? MEMRD : DONE;
          rdy_q <= ~is_load;
        end
        MEMRD: begin
          result_q <= rd_data;
          state    <= DONE;
          rdy_q    <= 1'b1;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = state == IDLE;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.error     = error_q;
  assign bus.cpu_rdy   = rdy_q;
endmodule

// File: tb/tb_cpu_core_param.sv
// Directed vector bench for cpu_core_param (WIDTH=8, NUM_IN=4,
// MEM_DEPTH=256): opcode table plus handshake and reset sequences.
module tb_cpu_core_param;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  cpu_core_param_if #(.WIDTH(8), .NUM_IN(4)) bus ();

  cpu_core_param #(
    .WIDTH(8),
    .NUM_IN(4),
    .MEM_DEPTH(256)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [1:0]  sa;
    logic [1:0]  sb;
    logic [31:0] din;
    logic [15:0] res;
    logic        z;
    logic        e;
    int          lat;
  } vec_t;

  localparam int NV = 21;
  vec_t tv [NV];

  task automatic check(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // issue one command, return cycles from accept to cpu_rdy
  task automatic run(
    input  logic [3:0]  op,
    input  logic [1:0]  sa,
    input  logic [1:0]  sb,
    input  logic [31:0] d,
    output int          lat
  );
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.cmd_ready && n < 20);
    if (!bus.cmd_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_wait: got 0 expected 1");
    end
    bus.cmd_in    = {op, sa, sb};
    bus.din       = d;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.cpu_rdy && lat < 10);
    if (!bus.cpu_rdy) lat = 99;
  endtask

  initial begin
    int lat;
    checks   = 0;
    failures = 0;

    tv[0]  = '{4'h0, 2'd0, 2'd1, 32'h0000_64C8, 16'h012C, 1'b0, 1'b0, 3};
    tv[1]  = '{4'h1, 2'd2, 2'd3, 32'h0505_0000, 16'h0000, 1'b1, 1'b0, 3};
    tv[2]  = '{4'h2, 2'd2, 2'd3, 32'hFFFF_0000, 16'hFE01, 1'b0, 1'b0, 3};
    tv[3]  = '{4'h3, 2'd0, 2'd1, 32'h0000_3CF0, 16'h0030, 1'b0, 1'b0, 3};
    tv[4]  = '{4'h4, 2'd0, 2'd1, 32'h0000_3CF0, 16'h00FC, 1'b0, 1'b0, 3};
    tv[5]  = '{4'h5, 2'd0, 2'd1, 32'h0000_3CF0, 16'h00CC, 1'b0, 1'b0, 3};
    tv[6]  = '{4'h6, 2'd0, 2'd0, 32'h0000_00F0, 16'h000F, 1'b0, 1'b0, 3};
    tv[7]  = '{4'h7, 2'd0, 2'd0, 32'h0000_00F0, 16'h01E0, 1'b0, 1'b0, 3};
    tv[8]  = '{4'h8, 2'd0, 2'd0, 32'h0000_00F1, 16'h0078, 1'b0, 1'b0, 3};
    tv[9]  = '{4'h1, 2'd0, 2'd1, 32'h0000_0503, 16'hFFFE, 1'b0, 1'b0, 3};
    tv[10] = '{4'h9, 2'd1, 2'd0, 32'h0000_3400, 16'h0034, 1'b0, 1'b0, 3};
    tv[11] = '{4'hD, 2'd0, 2'd0, 32'h0000_0010, 16'h0034, 1'b0, 1'b0, 3};
    tv[12] = '{4'h9, 2'd1, 2'd0, 32'h0000_0000, 16'h0000, 1'b1, 1'b0, 3};
    tv[13] = '{4'hC, 2'd0, 2'd0, 32'h0000_0010, 16'h0034, 1'b1, 1'b0, 4};
    tv[14] = '{4'hE, 2'd0, 2'd1, 32'h0000_0000, 16'h0034, 1'b1, 1'b1, 3};
    tv[15] = '{4'h0, 2'd0, 2'd1, 32'h0000_0201, 16'h0003, 1'b0, 1'b0, 3};
    tv[16] = '{4'hF, 2'd0, 2'd1, 32'h0000_FFFF, 16'h0003, 1'b0, 1'b0, 3};
    tv[17] = '{4'hA, 2'd0, 2'd1, 32'h0000_FFFF, 16'h0003, 1'b0, 1'b1, 3};
    tv[18] = '{4'h0, 2'd0, 2'd1, 32'h0000_FFFF, 16'h01FE, 1'b0, 1'b0, 3};
    tv[19] = '{4'hB, 2'd0, 2'd1, 32'h0000_0000, 16'h01FE, 1'b0, 1'b1, 3};
    tv[20] = '{4'h0, 2'd2, 2'd3, 32'h0000_FFFF, 16'h0000, 1'b1, 1'b0, 3};

    reset         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_in    = '0;
    bus.din       = '0;
    repeat (2) @(negedge clk);
    check("rst_result", bus.result, 16'h0);
    check("rst_zero", bus.zero, 1'b0);
    check("rst_error", bus.error, 1'b0);
    check("rst_cpu_rdy", bus.cpu_rdy, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready", bus.cmd_ready, 1'b1);

    for (int i = 0; i < NV; i++) begin
      run(tv[i].op, tv[i].sa, tv[i].sb, tv[i].din, lat);
      check($sformatf("v%0d_result", i), bus.result, tv[i].res);
      check($sformatf("v%0d_zero", i), bus.zero, tv[i].z);
      check($sformatf("v%0d_error", i), bus.error, tv[i].e);
      check($sformatf("v%0d_latency", i), lat, tv[i].lat);
    end

    // cmd_valid held high: one accept every 4 cycles
    @(negedge clk);
    bus.cmd_in    = {4'h0, 2'd0, 2'd1};
    bus.din       = 32'h0000_0201;
    bus.cmd_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      check($sformatf("b2b_ready_c%0d", c), bus.cmd_ready, c % 4 == 0);
      check($sformatf("b2b_rdy_c%0d", c), bus.cpu_rdy, c % 4 == 3);
    end
    bus.cmd_valid = 1'b0;
    check("b2b_result", bus.result, 16'h0003);

    // reset during EXEC of a STORE must not write memory
    run(4'h9, 2'd1, 2'd0, 32'h0000_7700, lat);
    run(4'hD, 2'd0, 2'd0, 32'h0000_0020, lat);
    run(4'h9, 2'd1, 2'd0, 32'h0000_5500, lat);
    check("pre_rst_result", bus.result, 16'h0055);
    @(negedge clk);
    bus.cmd_in    = {4'hD, 2'd0, 2'd0};
    bus.din       = 32'h0000_0020;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_result", bus.result, 16'h0);
    check("midrst_zero", bus.zero, 1'b0);
    check("midrst_error", bus.error, 1'b0);
    check("midrst_cpu_rdy", bus.cpu_rdy, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    run(4'hC, 2'd0, 2'd0, 32'h0000_0020, lat);
    check("midrst_mem_word", bus.result, 16'h0077);
    check("midrst_load_lat", lat, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
